spi_regfile_peripheral: RTL and testbench
=========================================

// Module: spi_regfile_peripheral
// PURPOSE
//   SPI (mode 0, MSB-first) target giving the controller write and optional read access to a parametrised register file.
//   Generalises the fixed 5x8-bit PWM config peripheral: register count, address and data widths are parameters.
//   Adds per-register write strobes, frame-error flagging and readback on CIPO.
//   Sits between the tt pins (SCLK/COPI/nCS/CIPO) and the PWM/config logic, which consumes regs_flat.
// PARAMETERS
//   ADDR_W    7   address field width in bits
//   DATA_W    8   data field / register width in bits
//   NUM_REGS  5   number of implemented registers, 1..2**ADDR_W; addresses >= NUM_REGS are unmapped
// PORTS
//   clk          in   1                  system clock, sole clock domain
//   rst          in   1                  synchronous, active-high reset
//   sclk         in   1                  SPI clock, asynchronous to clk
//   copi         in   1                  controller-out serial data, asynchronous
//   ncs          in   1                  active-low chip select, asynchronous
//   cipo         out  1                  controller-in serial data
//   cipo_oe      out  1                  CIPO output enable (pad driver)
//   regs_flat    out  NUM_REGS*DATA_W    register contents; reg i at [i*DATA_W +: DATA_W]
//   wr_strobe    out  NUM_REGS           1-cycle pulse on bit i when reg i is written
//   frame_err    out  1                  1-cycle pulse when a frame is discarded
// BEHAVIOUR
//   - Reset (rst high at posedge clk): all regs, cipo, cipo_oe, wr_strobe, frame_err = 0; counters/shifters cleared.
//     An in-flight frame is aborted and never commits.
//   - sclk, copi and ncs each pass through a 2-FF synchroniser; edges are detected on the synced value vs a 3rd FF.
//     Requires f_sclk <= f_clk/8.
//   - Frame layout: FRAME = 1+ADDR_W+DATA_W bits.
//     bit0 = R/W (1 = write, 0 = read); then addr MSB-first; then data MSB-first.
//     copi is sampled on each detected sclk rise while selected.
//   - Detected ncs fall: bit_cnt = 0, frame active, shifters cleared. A fall mid-frame restarts the frame.
//   - bit_cnt increments per detected sclk rise; saturates at FRAME+1 to mark overlong frames.
//   - Detected ncs rise ends the frame. In that clk cycle:
//     * Write commit: bit_cnt==FRAME, R/W=1 and addr<NUM_REGS -> reg[addr] <= data; wr_strobe[addr] = 1.
//       Update is visible the cycle after the detection cycle.
//     * frame_err = 1 if bit_cnt != FRAME (short, long or zero-length), or a write targets addr>=NUM_REGS; no reg changes.
//     * A valid read frame commits nothing and raises no error.
//   - An ncs rise and an sclk rise detected in the same cycle: ncs wins and the sclk edge is ignored.
//   - sclk edges while ncs is high are ignored.
//   - Only one frame commits per clk cycle, so there are no write-port collisions.
// CONFIGURATION
//   SPI_READBACK_EN defined:
//     - cipo_oe = synced ncs low while a frame is active.
//     - On the sclk rise capturing the last addr bit (bit_cnt -> 1+ADDR_W) with R/W=0:
//       load shadow = reg[addr] (0 if unmapped); cipo <= shadow MSB.
//     - On each detected sclk fall in the data phase: shift shadow left; cipo <= next bit.
//     - After the last data bit, or for write frames, cipo = 0.
//     - Shadow is a snapshot: a later write does not alter an in-progress read.
//   SPI_READBACK_EN undefined:
//     - cipo = 0 and cipo_oe = 0 always; shadow logic is not built.
//     - Read frames are accepted silently (no commit, no frame_err).
// TESTING
//   1 Reset: hold rst 2 cycles -> regs_flat = 0, cipo_oe = 0, no strobes.
//     Release and idle 100 cycles -> no change.
//   2 Write 0x80 0xA5 (reg0 <= A5), then 0x84 0x3C (reg4 <= 3C) ->
//     reg0 = A5, reg4 = 3C; wr_strobe = 5'b00001 then 5'b10000, one cycle each.
//   3 Short frame (15 bits, 0x81 then 7 data bits), then 17-bit frame ->
//     frame_err pulses twice; regs unchanged.
//   4 Write to addr 0x7F with data 0xFF -> frame_err = 1; regs unchanged; wr_strobe = 0.
//   5 (SPI_READBACK_EN) After test 2, read frame 0x04 0x00 ->
//     cipo shifts out 0x3C MSB-first; cipo_oe high only while ncs is low.
//     Read of 0x10 returns 0x00.
//   6 Abort: assert rst after 10 bits of a write -> no commit.
//     ncs re-fall mid-frame, then a full 16-bit write -> only the second frame commits.

Source files
------------

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an SPI controller and the register-file target.
// master: the controller side (drives SCLK/COPI/nCS, receives CIPO).
// slave:  the peripheral side (receives SCLK/COPI/nCS, drives CIPO and its enable).
interface spi_regfile_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  cipo,
        input  cipo_oe
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output cipo,
        output cipo_oe
    );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0, MSB-first target with write (and optional read) access to a
// parametrised register file.
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// The SPI pins are oversampled in the clk domain (f_sclk <= f_clk/8).
// Optional feature: define SPI_READBACK_EN to build CIPO readback of read frames;
// without it, cipo and cipo_oe are tied low and read frames are silently accepted.
module spi_regfile_peripheral #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_regfile_peripheral_if.slave    spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0]  CNT_FRAME    = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(FRAME + 1);
    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [2:0]             r_sclk_sync;
    logic [1:0]             r_copi_sync;
    logic [2:0]             r_ncs_sync;
    logic                   w_sclk_rise;
    logic                   w_ncs_fall;
    logic                   w_ncs_rise;
    logic                   w_copi;

    logic                   w_bit_take;
    logic                   w_frame_end;

    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME-1:0]       r_shift;
    logic [FRAME-1:0]       w_shift_next;

    logic                   w_rw;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;
    logic                   w_len_ok;
    logic                   w_mapped;
    logic                   w_commit;
    logic                   w_err;
    logic [NUM_REGS-1:0]    w_hit;

    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_strobe;
    logic                   r_frame_err;

    // Synchronise the asynchronous SPI pins; the 3rd stage gives the edge reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= 3'b000;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 3'b111;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi.sclk};
            r_copi_sync <= {r_copi_sync[0], spi.copi};
            r_ncs_sync  <= {r_ncs_sync[1:0], spi.ncs};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_sync[2];
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_sync[2];
    assign w_copi      = r_copi_sync[1];

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame next-state: ncs rise ends a frame and takes priority over a same-cycle sclk rise.
    always_comb begin
        w_state_next = r_state;
        w_bit_take   = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_ncs_rise) begin
                    w_state_next = ST_IDLE;
                    w_frame_end  = 1'b1;
                end else if (w_ncs_fall) begin
                    w_state_next = ST_ACTIVE;
                end else if (w_sclk_rise && !r_ncs_sync[1]) begin
                    w_bit_take = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_shift_next = {r_shift[FRAME-2:0], w_copi};

    // Bit counter (saturating one past a full frame) and frame shifter; an ncs fall restarts both.
    always_ff @(posedge clk) begin
        if (rst || w_ncs_fall) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_bit_take) begin
            if (r_bit_cnt != CNT_SAT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_bit_cnt < CNT_FRAME) begin
                r_shift <= w_shift_next;
            end
        end
    end

    assign w_rw     = r_shift[FRAME-1];
    assign w_addr   = r_shift[DATA_W +: ADDR_W];
    assign w_data   = r_shift[DATA_W-1:0];
    assign w_len_ok = (r_bit_cnt == CNT_FRAME);
    assign w_mapped = ({1'b0, w_addr} < NUM_REGS_EXT);
    assign w_commit = w_frame_end & w_len_ok & w_rw & w_mapped;
    assign w_err    = w_frame_end & (~w_len_ok | (w_rw & ~w_mapped));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_hit[gi] = w_commit && (w_addr == ADDR_W'(gi));
            assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

    // Register file write, per-register strobe and frame error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i]) begin
                    r_regs[i] <= w_data;
                end
            end
            r_wr_strobe <= w_hit;
            r_frame_err <= w_err;
        end
    end

    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
    logic                   w_sclk_fall;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_rd_rw;
    logic                   w_load;
    logic [DATA_W-1:0]      w_rd_val;
    logic [DATA_W-1:0]      w_shadow_shl;
    logic [DATA_W-1:0]      r_shadow;
    logic                   r_cipo;
    logic                   r_rd_active;

    assign w_sclk_fall  = ~r_sclk_sync[1] & r_sclk_sync[2];
    // Address is complete once the bit being taken is the last address bit.
    assign w_rd_addr    = w_shift_next[ADDR_W-1:0];
    assign w_rd_rw      = w_shift_next[ADDR_W];
    assign w_load       = w_bit_take && (r_bit_cnt == CNT_W'(ADDR_W)) && !w_rd_rw;
    assign w_shadow_shl = r_shadow << 1;

    // Readback source mux; unmapped addresses read as zero.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_addr == ADDR_W'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    // Shadow snapshot and CIPO shifting: MSB presented after the address, next bit on each data-phase fall.
    always_ff @(posedge clk) begin
        if (rst || w_ncs_fall || w_frame_end) begin
            r_shadow    <= '0;
            r_cipo      <= 1'b0;
            r_rd_active <= 1'b0;
        end else if (w_load) begin
            r_shadow    <= w_rd_val;
            r_cipo      <= w_rd_val[DATA_W-1];
            r_rd_active <= 1'b1;
        end else if (r_rd_active && w_sclk_fall && (r_state == ST_ACTIVE)) begin
            if (r_bit_cnt >= CNT_FRAME) begin
                r_cipo      <= 1'b0;
                r_rd_active <= 1'b0;
            end else if (r_bit_cnt > CNT_W'(ADDR_W + 1)) begin
                r_shadow <= w_shadow_shl;
                r_cipo   <= w_shadow_shl[DATA_W-1];
            end
        end
    end

    assign spi.cipo    = r_cipo;
    assign spi.cipo_oe = (r_state == ST_ACTIVE) & ~r_ncs_sync[1];
`else
    assign spi.cipo    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral (ADDR_W=7, DATA_W=8, NUM_REGS=5).
// Honours SPI_READBACK_EN the same way as the design.
module tb_spi_regfile_peripheral;

    localparam int HALF = 8;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] regs_flat;
    logic [4:0]  wr_strobe;
    logic        frame_err;

    spi_regfile_peripheral_if spi_bus ();

    spi_regfile_peripheral #(
        .ADDR_W   (7),
        .DATA_W   (8),
        .NUM_REGS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi_bus),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_strobe = 0;
    int         n_ferr   = 0;
    logic [4:0] strobe_log [4];

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe != 5'b0) begin
            if (n_strobe < 4) strobe_log[n_strobe] = wr_strobe;
            n_strobe++;
        end
        if (frame_err) n_ferr++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        n_strobe = 0;
        n_ferr   = 0;
        for (int i = 0; i < 4; i++) strobe_log[i] = 5'b0;
    endtask

    // Clock out nbits MSB-first (mode 0); sample cipo/cipo_oe just before each of the last 8 rises.
    task automatic clock_bits(input logic [31:0] bits, input int nbits,
                              output logic [7:0] rd, output logic oe_all, output logic oe_any);
        rd     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.copi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i >= nbits - 8) begin
                rd     = {rd[6:0], spi_bus.cipo};
                oe_all = oe_all & spi_bus.cipo_oe;
                oe_any = oe_any | spi_bus.cipo_oe;
            end
            spi_bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] bits, input int nbits,
                            output logic [7:0] rd, output logic oe_all, output logic oe_any);
        spi_bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits(bits, nbits, rd, oe_all, oe_any);
        repeat (HALF) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    logic [7:0] rd;
    logic       oe_all;
    logic       oe_any;

    initial begin
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        rst          = 1'b1;
        clear_mon();

        // 1: reset state, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_regs", regs_flat, 40'h0);
        check_val("rst_oe", spi_bus.cipo_oe, 1'b0);
        check_val("rst_cipo", spi_bus.cipo, 1'b0);
        check_val("rst_strobe", wr_strobe, 5'b0);
        rst = 1'b0;
        clear_mon();
        repeat (100) @(negedge clk);
        check_val("idle_regs", regs_flat, 40'h0);
        check_val("idle_pulses", n_strobe + n_ferr, 0);

        // 2: two writes
        clear_mon();
        spi_xfer({16'h0, 8'h80, 8'hA5}, 16, rd, oe_all, oe_any);
        spi_xfer({16'h0, 8'h84, 8'h3C}, 16, rd, oe_all, oe_any);
        check_val("wr_regs", regs_flat, 40'h3C_00_00_00_A5);
        check_val("wr_nstrobe", n_strobe, 2);
        check_val("wr_strobe0", strobe_log[0], 5'b00001);
        check_val("wr_strobe1", strobe_log[1], 5'b10000);
        check_val("wr_ferr", n_ferr, 0);

        // 3: short (15-bit) and long (17-bit) frames
        clear_mon();
        spi_xfer({17'h0, 8'h81, 7'h55}, 15, rd, oe_all, oe_any);
        spi_xfer({15'h0, 8'h81, 8'h12, 1'b1}, 17, rd, oe_all, oe_any);
        check_val("len_ferr", n_ferr, 2);
        check_val("len_regs", regs_flat, 40'h3C_00_00_00_A5);
        check_val("len_strobe", n_strobe, 0);

        // 4: write to unmapped address 0x7F
        clear_mon();
        spi_xfer({16'h0, 8'hFF, 8'hFF}, 16, rd, oe_all, oe_any);
        check_val("unmap_ferr", n_ferr, 1);
        check_val("unmap_regs", regs_flat, 40'h3C_00_00_00_A5);
        check_val("unmap_strobe", n_strobe, 0);

        // 5: read frames
        clear_mon();
        spi_xfer({16'h0, 8'h04, 8'h00}, 16, rd, oe_all, oe_any);
`ifdef SPI_READBACK_EN
        check_val("rd4_data", rd, 8'h3C);
        check_val("rd4_oe_on", oe_all, 1'b1);
`else
        check_val("rd4_data", rd, 8'h00);
        check_val("rd4_oe_off", oe_any, 1'b0);
`endif
        check_val("rd_oe_after", spi_bus.cipo_oe, 1'b0);
        check_val("rd_cipo_after", spi_bus.cipo, 1'b0);
        spi_xfer({16'h0, 8'h10, 8'h00}, 16, rd, oe_all, oe_any);
        check_val("rd10_data", rd, 8'h00);
        check_val("rd_ferr", n_ferr, 0);
        check_val("rd_strobe", n_strobe, 0);
        check_val("rd_regs", regs_flat, 40'h3C_00_00_00_A5);

        // 6a: reset after 10 bits of a write to reg3
        clear_mon();
        spi_bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits({22'h0, 10'b1000_0011_01}, 10, rd, oe_all, oe_any);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4 * HALF) @(negedge clk);
        check_val("abort_regs", regs_flat, 40'h0);
        check_val("abort_strobe", n_strobe, 0);
        check_val("abort_ferr", n_ferr, 0);

        // 6b: partial frame, ncs re-fall, then a full write to reg1
        clear_mon();
        spi_bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits({26'h0, 6'b100000}, 6, rd, oe_all, oe_any);
        repeat (HALF) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_xfer({16'h0, 8'h81, 8'h5A}, 16, rd, oe_all, oe_any);
        check_val("refall_regs", regs_flat, 40'h00_00_00_5A_00);
        check_val("refall_nstrobe", n_strobe, 1);
        check_val("refall_strobe", strobe_log[0], 5'b00010);
        check_val("refall_ferr", n_ferr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
